// File: rtl/spi_cfg_scheduler_if.sv
// Requester-side bundle of the SPI config scheduler: level requests with their
// config words in, grant/ack status and the serial-writer drive out.
interface spi_cfg_scheduler_if;
    logic [3:0]   req;
    logic [191:0] req_data;
    logic [3:0]   ack;
    logic         busy;
    logic [1:0]   grant_id;
    logic         spi_en;
    logic [63:0]  spi_word;
    logic [15:0]  xfer_count;

    modport master (
        output req, req_data,
        input  ack, busy, grant_id, spi_en, spi_word, xfer_count
    );

    modport slave (
        input  req, req_data,
        output ack, busy, grant_id, spi_en, spi_word, xfer_count
    );
endinterface

// File: rtl/spi_cfg_scheduler.sv
// Round-robin scheduler that hands one of four 48-bit config words at a time to
// a serial config writer, holding spi_en for a fixed window followed by a fixed gap.
module spi_cfg_scheduler #(
    parameter int XFER_CYCLES = 112,
    parameter int GAP_CYCLES  = 4
) (
    input  logic clk,
    input  logic rst,
    spi_cfg_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP
    } state_t;

    localparam logic [15:0] XFER_LAST = 16'(XFER_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [1:0]  last_grant;
    logic [1:0]  grant_id;
    logic [63:0] spi_word;
    logic        spi_en;
    logic        busy;
    logic [3:0]  ack;
    logic [15:0] xfer_cnt;
    logic [1:0]  pick;

    // Scan from furthest to nearest so the nearest set bit after last_grant wins.
    always_comb begin
        pick = last_grant;
        for (int off = 4; off >= 1; off--) begin
            if (bus.req[last_grant + 2'(off)]) begin
                pick = last_grant + 2'(off);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 2'd3;
            grant_id   <= '0;
            spi_word   <= '0;
            spi_en     <= 1'b0;
            busy       <= 1'b0;
            ack        <= '0;
            xfer_cnt   <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        grant_id   <= pick;
                        last_grant <= pick;
                        spi_word   <= {16'h0, bus.req_data[48*int'(pick) +: 48]};
                        spi_en     <= 1'b1;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        state      <= XFER;
                    end
                end
                XFER: begin
                    if (cnt == XFER_LAST) begin
                        spi_en <= 1'b0;
                        ack    <= 4'b0001 << grant_id;
                        if (xfer_cnt != 16'hFFFF) begin
                            xfer_cnt <= xfer_cnt + 16'd1;
                        end
                        cnt    <= '0;
                        state  <= GAP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack        = ack;
    assign bus.busy       = busy;
    assign bus.grant_id   = grant_id;
    assign bus.spi_en     = spi_en;
    assign bus.spi_word   = spi_word;
    assign bus.xfer_count = xfer_cnt;

endmodule

// File: tb/tb_spi_cfg_scheduler.sv
// Self-checking bench for spi_cfg_scheduler: each scenario task predicts grants,
// words, acks and counts from the round-robin and timing rules.
module tb_spi_cfg_scheduler;

    localparam int XC = 112;
    localparam int GC = 4;

    logic clk = 1'b0;
    logic rst;

    spi_cfg_scheduler_if bus ();

    spi_cfg_scheduler #(
        .XFER_CYCLES(XC),
        .GAP_CYCLES (GC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [1:0]  exp_last;
    logic [15:0] exp_count;

    int          o_wait, o_high, o_busy;
    logic [1:0]  o_gid;
    logic [63:0] o_word;
    bit          o_stable, o_early, o_to;
    logic [3:0]  o_ack, o_ack_next;
    logic [15:0] o_cnt;

    function automatic logic [1:0] rr_pick(logic [1:0] last, logic [3:0] mask);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (int'(last) + k) % 4;
            if (mask[i]) return 2'(i);
        end
        return last;
    endfunction

    function automatic logic [15:0] sat_inc(logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    function automatic logic [191:0] rand192();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] word_of(logic [191:0] data, logic [1:0] id);
        return {16'h0, data[48*int'(id) +: 48]};
    endfunction

    // Measures one complete transfer: rise latency, enable width, ack and busy tail.
    task automatic observe();
        o_to = 0; o_wait = 0; o_high = 0; o_busy = 0;
        o_stable = 1; o_early = 0; o_ack_next = 4'hF;
        while (1) begin
            @(negedge clk);
            o_wait++;
            if (bus.spi_en === 1'b1) break;
            if (o_wait >= 60) begin o_to = 1; return; end
        end
        o_gid  = bus.grant_id;
        o_word = bus.spi_word;
        while (bus.spi_en === 1'b1) begin
            o_high++;
            if (bus.spi_word !== o_word) o_stable = 0;
            if (bus.ack !== 4'b0000) o_early = 1;
            if (o_high >= 300) begin o_to = 1; return; end
            @(negedge clk);
        end
        o_ack = bus.ack;
        o_cnt = bus.xfer_count;
        while (bus.busy === 1'b1) begin
            o_busy++;
            if (o_busy == 2) o_ack_next = bus.ack;
            if (o_busy >= 50) begin o_to = 1; return; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.req_data = rand192();
        repeat (3) @(negedge clk);
        total++; if (bus.spi_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_spi_en: got %b expected 0", bus.spi_en); end
        total++; if (bus.ack !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ack: got %b expected 0000", bus.ack); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        total++; if (bus.spi_word !== 64'h0) begin bad++; $display("[TB] FAIL reset_word: got %h expected 0", bus.spi_word); end
        total++; if (bus.grant_id !== 2'd0) begin bad++; $display("[TB] FAIL reset_grant: got %0d expected 0", bus.grant_id); end
        total++; if (bus.xfer_count !== 16'h0) begin bad++; $display("[TB] FAIL reset_count: got %h expected 0", bus.xfer_count); end
        rst = 1'b0;
        exp_last  = 2'd3;
        exp_count = 16'h0;
    endtask

    task automatic test_single();
        logic [1:0] id;
        bus.req_data = rand192();
        bus.req_data[47:0] = 48'hA5A5_0000_1234;
        id = rr_pick(exp_last, 4'b0001);
        bus.req = 4'b0001;
        fork
            observe();
            begin @(negedge clk); bus.req = 4'b0000; end
        join
        exp_last = id; exp_count = sat_inc(exp_count);
        total++; if (o_to !== 1'b0) begin bad++; $display("[TB] FAIL single_timeout: got %b expected 0", o_to); end
        total++; if (o_wait !== 1) begin bad++; $display("[TB] FAIL single_latency: got %0d expected 1", o_wait); end
        total++; if (o_high !== XC) begin bad++; $display("[TB] FAIL single_width: got %0d expected %0d", o_high, XC); end
        total++; if (o_gid !== id) begin bad++; $display("[TB] FAIL single_grant: got %0d expected %0d", o_gid, id); end
        total++; if (o_word !== 64'h0000_A5A5_0000_1234) begin bad++; $display("[TB] FAIL single_word: got %h expected 0000a5a500001234", o_word); end
        total++; if (o_early !== 1'b0) begin bad++; $display("[TB] FAIL single_early_ack: got %b expected 0", o_early); end
        total++; if (o_ack !== 4'b0001) begin bad++; $display("[TB] FAIL single_ack: got %b expected 0001", o_ack); end
        total++; if (o_ack_next !== 4'b0000) begin bad++; $display("[TB] FAIL single_ack_width: got %b expected 0000", o_ack_next); end
        total++; if (o_cnt !== exp_count) begin bad++; $display("[TB] FAIL single_count: got %h expected %h", o_cnt, exp_count); end
        total++; if (o_busy !== GC) begin bad++; $display("[TB] FAIL single_busy_tail: got %0d expected %0d", o_busy, GC); end
        repeat (5) @(negedge clk);
        total++; if (bus.spi_en !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_hold_en_busy: got %b%b expected 00", bus.spi_en, bus.busy); end
        total++; if (bus.spi_word !== 64'h0000_A5A5_0000_1234) begin bad++; $display("[TB] FAIL idle_hold_word: got %h expected 0000a5a500001234", bus.spi_word); end
        total++; if (bus.xfer_count !== exp_count) begin bad++; $display("[TB] FAIL idle_hold_count: got %h expected %h", bus.xfer_count, exp_count); end
    endtask

    task automatic test_all_four();
        logic [1:0]  id;
        logic [63:0] w;
        int          prev_busy;
        @(negedge clk);
        rst = 1'b1;
        bus.req = 4'b1111;
        bus.req_data = rand192();
        @(negedge clk);
        rst = 1'b0;
        exp_last = 2'd3; exp_count = 16'h0; prev_busy = 0;
        for (int n = 0; n < 5; n++) begin
            id = rr_pick(exp_last, 4'b1111);
            w  = word_of(bus.req_data, id);
            observe();
            exp_last = id; exp_count = sat_inc(exp_count);
            total++; if (o_to !== 1'b0) begin bad++; $display("[TB] FAIL all4_timeout[%0d]: got %b expected 0", n, o_to); end
            total++; if (o_gid !== id) begin bad++; $display("[TB] FAIL all4_grant[%0d]: got %0d expected %0d", n, o_gid, id); end
            total++; if (o_ack !== (4'b0001 << id)) begin bad++; $display("[TB] FAIL all4_ack[%0d]: got %b expected %b", n, o_ack, 4'b0001 << id); end
            total++; if (o_word !== w) begin bad++; $display("[TB] FAIL all4_word[%0d]: got %h expected %h", n, o_word, w); end
            total++; if (o_cnt !== exp_count) begin bad++; $display("[TB] FAIL all4_count[%0d]: got %h expected %h", n, o_cnt, exp_count); end
            if (n == 0) begin
                total++; if (o_wait !== 1) begin bad++; $display("[TB] FAIL all4_first_latency: got %0d expected 1", o_wait); end
            end else begin
                total++; if (prev_busy + o_wait !== GC + 1) begin bad++; $display("[TB] FAIL all4_gap[%0d]: got %0d expected %0d", n, prev_busy + o_wait, GC + 1); end
            end
            prev_busy = o_busy;
        end
    endtask

    task automatic test_data_change();
        logic [1:0]  id;
        logic [63:0] w;
        id = rr_pick(exp_last, 4'b0100);
        bus.req_data[96 +: 48] = {$urandom(), 16'($urandom())};
        w = word_of(bus.req_data, 2'd2);
        bus.req = 4'b0100;
        fork
            observe();
            begin
                int n;
                n = 0;
                while (bus.spi_en !== 1'b1 && n < 60) begin @(negedge clk); n++; end
                repeat (10) @(negedge clk);
                bus.req_data[96 +: 48] = ~bus.req_data[96 +: 48];
                bus.req = 4'b0000;
            end
        join
        exp_last = id; exp_count = sat_inc(exp_count);
        total++; if (o_gid !== id) begin bad++; $display("[TB] FAIL datachg_grant: got %0d expected %0d", o_gid, id); end
        total++; if (o_word !== w) begin bad++; $display("[TB] FAIL datachg_word: got %h expected %h", o_word, w); end
        total++; if (o_stable !== 1'b1) begin bad++; $display("[TB] FAIL datachg_stable: got %b expected 1", o_stable); end
        total++; if (o_ack !== 4'b0100) begin bad++; $display("[TB] FAIL datachg_ack: got %b expected 0100", o_ack); end
        total++; if (bus.spi_word !== w) begin bad++; $display("[TB] FAIL datachg_word_after: got %h expected %h", bus.spi_word, w); end
    endtask

    task automatic test_withdraw();
        logic [1:0] id;
        id = rr_pick(exp_last, 4'b0010);
        bus.req = 4'b0010;
        fork
            observe();
            begin
                int n;
                n = 0;
                while (bus.spi_en !== 1'b1 && n < 60) begin @(negedge clk); n++; end
                repeat (20) @(negedge clk);
                bus.req = 4'b1001;
            end
        join
        exp_last = id; exp_count = sat_inc(exp_count);
        total++; if (o_gid !== id) begin bad++; $display("[TB] FAIL withdraw_grant: got %0d expected %0d", o_gid, id); end
        total++; if (o_high !== XC) begin bad++; $display("[TB] FAIL withdraw_width: got %0d expected %0d", o_high, XC); end
        total++; if (o_ack !== 4'b0010) begin bad++; $display("[TB] FAIL withdraw_ack: got %b expected 0010", o_ack); end
        id = rr_pick(exp_last, 4'b1001);
        fork
            observe();
            begin @(negedge clk); bus.req = 4'b0000; end
        join
        exp_last = id; exp_count = sat_inc(exp_count);
        total++; if (o_gid !== id) begin bad++; $display("[TB] FAIL withdraw_next_grant: got %0d expected %0d", o_gid, id); end
        total++; if (o_ack !== (4'b0001 << id)) begin bad++; $display("[TB] FAIL withdraw_next_ack: got %b expected %b", o_ack, 4'b0001 << id); end
        total++; if (o_cnt !== exp_count) begin bad++; $display("[TB] FAIL withdraw_count: got %h expected %h", o_cnt, exp_count); end
    endtask

    task automatic test_random();
        logic [3:0]  mask;
        logic [1:0]  id;
        logic [63:0] w;
        for (int r = 0; r < 6; r++) begin
            mask = 4'($urandom_range(1, 15));
            bus.req_data = rand192();
            id = rr_pick(exp_last, mask);
            w  = word_of(bus.req_data, id);
            bus.req = mask;
            fork
                observe();
                begin @(negedge clk); bus.req = 4'b0000; end
            join
            exp_last = id; exp_count = sat_inc(exp_count);
            total++; if (o_gid !== id) begin bad++; $display("[TB] FAIL rand_grant[%0d]: got %0d expected %0d (mask %b)", r, o_gid, id, mask); end
            total++; if (o_word !== w) begin bad++; $display("[TB] FAIL rand_word[%0d]: got %h expected %h", r, o_word, w); end
            total++; if (o_ack !== (4'b0001 << id)) begin bad++; $display("[TB] FAIL rand_ack[%0d]: got %b expected %b", r, o_ack, 4'b0001 << id); end
            total++; if (o_cnt !== exp_count) begin bad++; $display("[TB] FAIL rand_count[%0d]: got %h expected %h", r, o_cnt, exp_count); end
            total++; if (o_wait !== 1) begin bad++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected 1", r, o_wait); end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] id;
        int         n;
        id = rr_pick(exp_last, 4'b1111);
        bus.req = 4'b1111;
        n = 0;
        while (bus.spi_en !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        total++; if (bus.grant_id !== id || bus.spi_en !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_grant: got %0d/%b expected %0d/1", bus.grant_id, bus.spi_en, id); end
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (bus.spi_en !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_spi_en: got %b expected 0", bus.spi_en); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy: got %b expected 0", bus.busy); end
        total++; if (bus.ack !== 4'b0000) begin bad++; $display("[TB] FAIL rstmid_ack: got %b expected 0000", bus.ack); end
        total++; if (bus.xfer_count !== 16'h0) begin bad++; $display("[TB] FAIL rstmid_count: got %h expected 0", bus.xfer_count); end
        exp_last = 2'd3; exp_count = 16'h0;
        id = rr_pick(exp_last, 4'b1111);
        observe();
        exp_last = id; exp_count = sat_inc(exp_count);
        bus.req = 4'b0000;
        total++; if (o_wait !== 1) begin bad++; $display("[TB] FAIL rstmid_relatency: got %0d expected 1", o_wait); end
        total++; if (o_gid !== id) begin bad++; $display("[TB] FAIL rstmid_regrant: got %0d expected %0d", o_gid, id); end
        total++; if (o_ack !== (4'b0001 << id)) begin bad++; $display("[TB] FAIL rstmid_reack: got %b expected %b", o_ack, 4'b0001 << id); end
        total++; if (o_cnt !== exp_count) begin bad++; $display("[TB] FAIL rstmid_recount: got %h expected %h", o_cnt, exp_count); end
    endtask

    task automatic test_saturation();
        logic [3:0] mask;
        logic [1:0] id;
        bus.req = 4'b0000;
        @(negedge clk);
        force dut.xfer_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.xfer_cnt;
        @(negedge clk);
        exp_count = 16'hFFFE;
        total++; if (bus.xfer_count !== exp_count) begin bad++; $display("[TB] FAIL sat_preload: got %h expected %h", bus.xfer_count, exp_count); end
        for (int r = 0; r < 2; r++) begin
            mask = 4'($urandom_range(1, 15));
            id = rr_pick(exp_last, mask);
            bus.req = mask;
            fork
                observe();
                begin @(negedge clk); bus.req = 4'b0000; end
            join
            exp_last = id; exp_count = sat_inc(exp_count);
            total++; if (o_cnt !== exp_count) begin bad++; $display("[TB] FAIL sat_count[%0d]: got %h expected %h", r, o_cnt, exp_count); end
            total++; if (o_gid !== id) begin bad++; $display("[TB] FAIL sat_grant[%0d]: got %0d expected %0d", r, o_gid, id); end
        end
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.req = 4'b0000;
        bus.req_data = '0;
        rst = 1'b1;
        test_reset();
        test_single();
        test_all_four();
        test_data_change();
        test_withdraw();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_cfg_scheduler.md
SPI_CFG_SCHEDULER -- requirements
Module: spi_cfg_scheduler

Interface
REQ-001 Parameter XFER_CYCLES, default 112: number of cycles spi_en is held high per transfer; SHALL be at least 105.
REQ-002 Parameter GAP_CYCLES, default 4: number of cycles spi_en is held low between transfers; SHALL be at least 2.
REQ-003 clk  input  1  single system clock; all logic is on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  4  per-requester level request; bit i is requester i.
REQ-006 req_data  input  192  per-requester 48-bit config words; requester i uses bits [48i+47:48i].
REQ-007 ack  output  4  one-cycle completion pulse, one-hot, for the granted requester.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 grant_id  output  2  index of the requester currently or last granted.
REQ-010 spi_en  output  1  enable to the serial config writer; it starts on a rising edge of spi_en.
REQ-011 spi_word  output  64  word to the writer; bits [63:48] are always 0.
REQ-012 xfer_count  output  16  count of completed transfers; saturates at 16'hFFFF.

Function
REQ-013 The FSM SHALL have three states, IDLE, XFER and GAP, with a 16-bit cycle counter cnt.
REQ-014 IDLE with req==0: the block SHALL hold all outputs.
REQ-015 IDLE with req!=0: the block SHALL grant round-robin, searching from (last_grant+1) mod 4 upward with wrap-around to the first set bit.
- On grant: latch grant_id, load spi_word={16'h0, req_data slice}, set spi_en<=1, cnt<=0, go to XFER.
- spi_en is therefore high on the cycle after req is first seen.
REQ-016 XFER: cnt SHALL increment each cycle.
- When cnt==XFER_CYCLES-1: spi_en<=0, ack[grant_id]<=1 for exactly one cycle, xfer_count increments (saturating), cnt<=0, go to GAP.
- spi_en is therefore high for exactly XFER_CYCLES cycles.
REQ-017 GAP: spi_en SHALL stay 0.
- When cnt==GAP_CYCLES-1: go to IDLE. Otherwise cnt increments.
- Back-to-back transfers are therefore separated by GAP_CYCLES+1 low cycles minimum.
REQ-018 spi_word and grant_id SHALL be stable from the grant until the next grant; changes to req_data after the grant have no effect.
REQ-019 If req[grant_id] drops during XFER or GAP, the transfer SHALL still complete and ack SHALL still pulse; no abort exists.
REQ-020 Requests are levels. A requester holding req after its ack SHALL be re-arbitrated fairly; it is served again only after the other pending requesters.
REQ-021 New requests arriving during XFER or GAP SHALL be considered only in IDLE.
REQ-022 ack SHALL never have more than one bit set, and SHALL be zero in all cycles except the XFER-to-GAP transition.

Reset
REQ-023 With rst high at a clock edge, the block SHALL go to IDLE with:
- spi_en=0, ack=0, busy=0, spi_word=0, grant_id=0, xfer_count=0, cnt=0
- last_grant=3, so requester 0 wins first.
REQ-024 Reset during XFER SHALL drop spi_en on that edge, and no ack SHALL be issued for the aborted transfer.
REQ-025 Reset SHALL take priority over all other events in the same cycle.

Verification
REQ-026 Single request: req=4'b0001, req_data[47:0]=48'hA5A5_0000_1234.
- spi_en rises 1 cycle later, spi_word=64'h0000_A5A5_0000_1234.
- spi_en stays high for 112 cycles, then ack=4'b0001 for 1 cycle, xfer_count=1, busy low 4 cycles after ack.
REQ-027 All four requesting continuously from reset: grant order SHALL be 0,1,2,3,0 and ack order the same.
- spi_en low gap is at least 5 cycles between transfers.
REQ-028 Data change after grant: req_data slice 2 is modified 10 cycles into requester 2's transfer; spi_word SHALL keep the grant-time value.
REQ-029 Request withdrawn: req[1] drops 20 cycles into its XFER; ack[1] SHALL still pulse at cycle 112 and the next grant follows the round-robin rule.
REQ-030 Reset mid-transfer: rst for 1 cycle at XFER cnt=50.
- spi_en=0, busy=0, ack=0 and xfer_count=0 on the next cycle.
- With req=4'b1111 afterwards, the next grant SHALL be requester 0.
REQ-031 Saturation: xfer_count is forced to 16'hFFFE and two transfers are run; xfer_count SHALL read 16'hFFFF after each.
